// File: rtl/axi_rd_sched.sv
// Read-path scheduler for the 2x2 AXI interconnect: round-robin grant of the shared
// AR/R path, slave decode from ARADDR, and a DATA-phase watchdog.
module axi_rd_sched #(
  parameter int ADDR_BITS   = 32,
  parameter int SEL_BIT     = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic                 ARVALID_M0,
  output logic                 ARREADY_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M1,
  output logic                 ARVALID_S0,
  output logic                 ARVALID_S1,
  input  logic                 ARREADY_S0,
  input  logic                 ARREADY_S1,
  input  logic                 RVALID_S0,
  input  logic                 RVALID_S1,
  input  logic                 RLAST_S0,
  input  logic                 RLAST_S1,
  output logic                 RREADY_S0,
  output logic                 RREADY_S1,
  output logic                 RVALID_M0,
  output logic                 RVALID_M1,
  input  logic                 RREADY_M0,
  input  logic                 RREADY_M1,
  output logic                 m_sel,
  output logic                 s_sel,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] WDOG_LIMIT = WDOG_EN ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] WDOG_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             m_sel_q, m_sel_d;
  logic             s_sel_q, s_sel_d;
  logic             last_gnt_q, last_gnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;

  logic gnt_s;
  logic arvalid_m_s;
  logic arready_s_s;
  logic rvalid_s_s;
  logic rlast_s_s;
  logic rready_m_s;
  logic addr_unused_s;

  // Only the select bit of each address matters here; the payload muxes use the rest.
  assign addr_unused_s = ^{ARADDR_M0, ARADDR_M1};

  // With both masters requesting, the one that did not win last time gets the path.
  assign gnt_s       = (ARVALID_M0 && ARVALID_M1) ? ~last_gnt_q : ARVALID_M1;
  assign arvalid_m_s = m_sel_q ? ARVALID_M1 : ARVALID_M0;
  assign arready_s_s = s_sel_q ? ARREADY_S1 : ARREADY_S0;
  assign rvalid_s_s  = s_sel_q ? RVALID_S1  : RVALID_S0;
  assign rlast_s_s   = s_sel_q ? RLAST_S1   : RLAST_S0;
  assign rready_m_s  = m_sel_q ? RREADY_M1  : RREADY_M0;

  // Next-state, watchdog and the valid/ready gating for the locked master/slave pair.
  always_comb begin
    state_d       = state_q;
    m_sel_d       = m_sel_q;
    s_sel_d       = s_sel_q;
    last_gnt_d    = last_gnt_q;
    wdog_d        = wdog_q;
    timeout_err_d = 1'b0;
    ARVALID_S0    = 1'b0;
    ARVALID_S1    = 1'b0;
    ARREADY_M0    = 1'b0;
    ARREADY_M1    = 1'b0;
    RVALID_M0     = 1'b0;
    RVALID_M1     = 1'b0;
    RREADY_S0     = 1'b0;
    RREADY_S1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          m_sel_d = gnt_s;
          s_sel_d = gnt_s ? ARADDR_M1[SEL_BIT] : ARADDR_M0[SEL_BIT];
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        ARVALID_S0 = !s_sel_q && arvalid_m_s;
        ARVALID_S1 =  s_sel_q && arvalid_m_s;
        ARREADY_M0 = !m_sel_q && arready_s_s;
        ARREADY_M1 =  m_sel_q && arready_s_s;
        if (arvalid_m_s && arready_s_s) begin
          last_gnt_d = m_sel_q;
          wdog_d     = {CNT_W{1'b0}};
          state_d    = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        RVALID_M0 = !m_sel_q && rvalid_s_s;
        RVALID_M1 =  m_sel_q && rvalid_s_s;
        RREADY_S0 = !s_sel_q && rready_m_s;
        RREADY_S1 =  s_sel_q && rready_m_s;
        if (rvalid_s_s && rready_m_s) begin
          wdog_d  = {CNT_W{1'b0}};
          state_d = rlast_s_s ? IDLE : DATA;
        end else if (WDOG_EN && (wdog_q >= WDOG_LIMIT)) begin
          // Stalled transfer: give the path up and let the other master in next.
          wdog_d        = {CNT_W{1'b0}};
          timeout_err_d = 1'b1;
          last_gnt_d    = m_sel_q;
          state_d       = IDLE;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + CNT_W'(1);
        end else begin
          wdog_d = wdog_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; last_gnt resets to M1 so M0 wins the first contested arbitration.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      m_sel_q       <= 1'b0;
      s_sel_q       <= 1'b0;
      last_gnt_q    <= 1'b1;
      wdog_q        <= {CNT_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_sel_q       <= m_sel_d;
      s_sel_q       <= s_sel_d;
      last_gnt_q    <= last_gnt_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign m_sel       = m_sel_q;
  assign s_sel       = s_sel_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_rd_sched.sv
// Directed bench for axi_rd_sched: arbitration order, gating/isolation, backpressure,
// watchdog abort (TIMEOUT_CYC = 8) and asynchronous reset mid-burst.
module tb_axi_rd_sched;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] araddr_m0, araddr_m1;
  logic [1:0]  arvalid_m, arready_s, rvalid_s, rlast_s, rready_m;
  wire  [1:0]  arready_m, arvalid_s, rready_s, rvalid_m;
  wire         m_sel, s_sel, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_sched #(.ADDR_BITS(32), .SEL_BIT(16), .TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARADDR_M0(araddr_m0), .ARVALID_M0(arvalid_m[0]), .ARREADY_M0(arready_m[0]),
    .ARADDR_M1(araddr_m1), .ARVALID_M1(arvalid_m[1]), .ARREADY_M1(arready_m[1]),
    .ARVALID_S0(arvalid_s[0]), .ARVALID_S1(arvalid_s[1]),
    .ARREADY_S0(arready_s[0]), .ARREADY_S1(arready_s[1]),
    .RVALID_S0(rvalid_s[0]), .RVALID_S1(rvalid_s[1]),
    .RLAST_S0(rlast_s[0]), .RLAST_S1(rlast_s[1]),
    .RREADY_S0(rready_s[0]), .RREADY_S1(rready_s[1]),
    .RVALID_M0(rvalid_m[0]), .RVALID_M1(rvalid_m[1]),
    .RREADY_M0(rready_m[0]), .RREADY_M1(rready_m[1]),
    .m_sel(m_sel), .s_sel(s_sel), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    araddr_m0 = 32'h0;
    araddr_m1 = 32'h0;
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    rvalid_s  = 2'b00;
    rlast_s   = 2'b00;
    rready_m  = 2'b00;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    tick();
    tick();
    ARESETn = 1'b1;
  endtask

  initial begin
    ARESETn = 1'b0;
    clear_inputs();
    tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_msel", {31'd0, m_sel}, 32'd0);
    check_eq("rst_ssel", {31'd0, s_sel}, 32'd0);
    check_eq("rst_terr", {31'd0, timeout_err}, 32'd0);
    check_eq("rst_gated", {24'd0, arready_m, arvalid_s, rready_s, rvalid_m}, 32'd0);

    // Single request M0 -> S0 with a 4-beat burst
    do_reset();
    araddr_m0 = 32'h0000_1000;
    arvalid_m = 2'b01;
    #1;
    check_eq("single_idle_arvs", {30'd0, arvalid_s}, 32'd0);
    tick();
    check_eq("single_busy", {31'd0, busy}, 32'd1);
    check_eq("single_msel", {31'd0, m_sel}, 32'd0);
    check_eq("single_ssel", {31'd0, s_sel}, 32'd0);
    check_eq("single_arvs", {30'd0, arvalid_s}, 32'd1);
    check_eq("single_arrm_wait", {30'd0, arready_m}, 32'd0);
    arready_s = 2'b01;
    #1;
    check_eq("single_arrm", {30'd0, arready_m}, 32'd1);
    tick();
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    rready_m  = 2'b01;
    for (int b = 1; b <= 4; b++) begin
      rvalid_s = 2'b01;
      rlast_s  = (b == 4) ? 2'b01 : 2'b00;
      #1;
      check_eq("single_rvm", {30'd0, rvalid_m}, 32'd1);
      check_eq("single_rrs", {30'd0, rready_s}, 32'd1);
      check_eq("single_busy_data", {31'd0, busy}, 32'd1);
      tick();
    end
    rvalid_s = 2'b00;
    rlast_s  = 2'b00;
    #1;
    check_eq("single_done_busy", {31'd0, busy}, 32'd0);

    // Simultaneous requests: M0 first, then M1 after one IDLE cycle, then M0 again
    do_reset();
    araddr_m0 = 32'h0000_1000;
    araddr_m1 = 32'h0001_0000;
    arvalid_m = 2'b11;
    tick();
    check_eq("sim1_msel", {31'd0, m_sel}, 32'd0);
    check_eq("sim1_ssel", {31'd0, s_sel}, 32'd0);
    check_eq("sim1_arvs", {30'd0, arvalid_s}, 32'd1);
    arready_s = 2'b11;
    #1;
    check_eq("sim1_arrm", {30'd0, arready_m}, 32'd1);
    tick();
    arvalid_m = 2'b10;
    arready_s = 2'b00;
    rready_m  = 2'b11;
    rvalid_s  = 2'b01;
    rlast_s   = 2'b01;
    #1;
    check_eq("sim1_rvm", {30'd0, rvalid_m}, 32'd1);
    check_eq("sim1_arrm_data", {30'd0, arready_m}, 32'd0);
    tick();
    rvalid_s = 2'b00;
    rlast_s  = 2'b00;
    #1;
    check_eq("sim_bubble_busy", {31'd0, busy}, 32'd0);
    check_eq("sim_bubble_arvs", {30'd0, arvalid_s}, 32'd0);
    tick();
    check_eq("sim2_msel", {31'd0, m_sel}, 32'd1);
    check_eq("sim2_ssel", {31'd0, s_sel}, 32'd1);
    check_eq("sim2_arvs", {30'd0, arvalid_s}, 32'd2);
    arready_s = 2'b10;
    #1;
    check_eq("sim2_arrm", {30'd0, arready_m}, 32'd2);
    tick();
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    rvalid_s  = 2'b10;
    rlast_s   = 2'b10;
    #1;
    check_eq("sim2_rvm", {30'd0, rvalid_m}, 32'd2);
    tick();
    rvalid_s  = 2'b00;
    rlast_s   = 2'b00;
    arvalid_m = 2'b11;
    tick();
    check_eq("sim3_msel", {31'd0, m_sel}, 32'd0);

    // Backpressure on M1 -> S1 for 5 cycles
    do_reset();
    araddr_m1 = 32'h0001_0000;
    arvalid_m = 2'b10;
    tick();
    arready_s = 2'b10;
    tick();
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    rvalid_s  = 2'b10;
    rready_m  = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("bp_rvm", {30'd0, rvalid_m}, 32'd2);
      check_eq("bp_rrs", {30'd0, rready_s}, 32'd0);
      check_eq("bp_busy", {31'd0, busy}, 32'd1);
      check_eq("bp_terr", {31'd0, timeout_err}, 32'd0);
      tick();
    end
    rready_m = 2'b10;
    rlast_s  = 2'b10;
    #1;
    check_eq("bp_rrs_go", {30'd0, rready_s}, 32'd2);
    tick();
    rvalid_s = 2'b00;
    rlast_s  = 2'b00;
    #1;
    check_eq("bp_done_busy", {31'd0, busy}, 32'd0);
    check_eq("bp_done_terr", {31'd0, timeout_err}, 32'd0);

    // Isolation: M0 -> S1 while S0 and M1 are active; S0's RLAST must be ignored
    do_reset();
    araddr_m0 = 32'h0001_0000;
    arvalid_m = 2'b01;
    tick();
    check_eq("iso_ssel", {31'd0, s_sel}, 32'd1);
    arvalid_m = 2'b11;
    arready_s = 2'b11;
    #1;
    check_eq("iso_arvs", {30'd0, arvalid_s}, 32'd2);
    check_eq("iso_arrm", {30'd0, arready_m}, 32'd1);
    tick();
    arvalid_m = 2'b10;
    arready_s = 2'b00;
    rvalid_s  = 2'b11;
    rready_m  = 2'b11;
    rlast_s   = 2'b01;
    for (int b = 0; b < 3; b++) begin
      #1;
      check_eq("iso_rvm", {30'd0, rvalid_m}, 32'd1);
      check_eq("iso_rrs", {30'd0, rready_s}, 32'd2);
      check_eq("iso_arrm_data", {30'd0, arready_m}, 32'd0);
      check_eq("iso_busy", {31'd0, busy}, 32'd1);
      tick();
    end

    // Watchdog: slave never answers, abort 8 cycles after entering DATA
    do_reset();
    arvalid_m = 2'b01;
    tick();
    arready_s = 2'b01;
    tick();
    arvalid_m = 2'b11;
    arready_s = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check_eq("wd_wait_terr", {31'd0, timeout_err}, 32'd0);
      check_eq("wd_wait_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    check_eq("wd_terr", {31'd0, timeout_err}, 32'd1);
    check_eq("wd_idle", {31'd0, busy}, 32'd0);
    tick();
    check_eq("wd_terr_pulse", {31'd0, timeout_err}, 32'd0);
    check_eq("wd_next_msel", {31'd0, m_sel}, 32'd1);

    // Reset asserted during beat 2 of an M0 burst
    do_reset();
    arvalid_m = 2'b01;
    tick();
    arready_s = 2'b01;
    tick();
    arvalid_m = 2'b00;
    arready_s = 2'b00;
    rvalid_s  = 2'b01;
    rready_m  = 2'b01;
    tick();
    #1;
    check_eq("mid_beat2_rvm", {30'd0, rvalid_m}, 32'd1);
    ARESETn = 1'b0;
    #1;
    check_eq("mid_rst_gated", {24'd0, arready_m, arvalid_s, rready_s, rvalid_m}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    clear_inputs();
    tick();
    ARESETn = 1'b1;
    arvalid_m = 2'b11;
    araddr_m1 = 32'h0001_0000;
    tick();
    check_eq("mid_after_msel", {31'd0, m_sel}, 32'd0);
    check_eq("mid_after_busy", {31'd0, busy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_sched.md
Name: axi_rd_sched

Overview:
- Read-path scheduler for the 2-master / 2-slave AXI interconnect.
- Shares the single read path (AR + R channels) between M0 and M1 using round-robin arbitration.
- Decodes the target slave from the granted master's ARADDR and locks the path until the final R beat (RLAST handshake) completes.
- Drives only valid/ready gating and select lines; the existing payload muxes (ID/ADDR/DATA/RESP) consume m_sel/s_sel.

Parameters:
- ADDR_BITS, 32, ARADDR width (matches AXI_ADDR_BITS)
- SEL_BIT, 16, ARADDR bit that selects the slave: 0 -> S0, 1 -> S1
- TIMEOUT_CYC, 256, idle cycles allowed in DATA before abort; 0 disables the watchdog

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARADDR_M0  in  ADDR_BITS  M0 read address, used for decode only
- ARVALID_M0  in  1  M0 read request
- ARREADY_M0  out  1  gated ready to M0
- ARADDR_M1  in  ADDR_BITS  M1 read address
- ARVALID_M1  in  1  M1 read request
- ARREADY_M1  out  1  gated ready to M1
- ARVALID_S0 / ARVALID_S1  out  1 each  gated valid to slave
- ARREADY_S0 / ARREADY_S1  in  1 each  slave address ready
- RVALID_S0 / RVALID_S1  in  1 each  slave read-data valid
- RLAST_S0 / RLAST_S1  in  1 each  slave last beat
- RREADY_S0 / RREADY_S1  out  1 each  gated ready to slave
- RVALID_M0 / RVALID_M1  out  1 each  gated valid to master
- RREADY_M0 / RREADY_M1  in  1 each  master read-data ready
- m_sel  out  1  granted master (0 = M0, 1 = M1), registered
- s_sel  out  1  targeted slave, registered
- busy  out  1  high in ADDR or DATA
- timeout_err  out  1  one-cycle pulse when the watchdog aborts

Behaviour:
- Reset (asynchronous, ARESETn = 0):
  - state = IDLE; all gated outputs, m_sel, s_sel, busy and timeout_err = 0.
  - Round-robin pointer last_gnt = 1, so M0 has priority on the first arbitration.
  - Reset mid-transfer aborts immediately, with no handshake completion.
- Gating: every gated output not belonging to the selected master/slave pair is 0 in all states. In IDLE, all gated outputs are 0.
- IDLE:
  - If exactly one ARVALID_Mx is high, grant that master.
  - If both are high, grant the master that is not last_gnt.
  - On a grant, register m_sel and s_sel = ARADDR_Mm[SEL_BIT], then go to ADDR.
  - Grant-to-ARVALID_S latency is 1 cycle.
- ADDR:
  - ARVALID_S[s_sel] = ARVALID_M[m_sel]; ARREADY_M[m_sel] = ARREADY_S[s_sel] (combinational pass-through).
  - When both valid and ready are high: last_gnt <= m_sel, clear the watchdog, go to DATA.
  - If the master drops ARVALID, remain in ADDR; the grant is held.
- DATA:
  - RVALID_M[m_sel] = RVALID_S[s_sel]; RREADY_S[s_sel] = RREADY_M[m_sel].
  - A handshake with RLAST_S[s_sel] = 1 returns to IDLE in the next cycle. The path is then free, and re-arbitration happens in that IDLE cycle, so there is at least 1 bubble cycle between bursts.
  - A handshake without RLAST clears the watchdog.
- Watchdog (DATA only):
  - Counter width is $clog2(TIMEOUT_CYC) + 1; it saturates and never wraps.
  - It increments on each DATA cycle without a beat handshake.
  - When it reaches TIMEOUT_CYC - 1: pulse timeout_err for 1 cycle, force IDLE, and set last_gnt = m_sel.
- busy = (state != IDLE).
- A requester that is not granted sees ARREADY = 0 and must hold its request; it is never lost.

Test Plan:
- Single request: after reset, M0 ARVALID with ARADDR = 0x0000_1000 → m_sel = 0, s_sel = 0, ARVALID_S0 = 1 in cycle 2. ARREADY_S0 = 1 → ARREADY_M0 = 1. A 4-beat burst with RLAST on beat 4 → back to IDLE, busy = 0.
- Simultaneous requests: both masters assert, M1 ARADDR = 0x0001_0000.
  - M0 is granted first, to S0.
  - After M0's RLAST handshake, M1 is granted 1 IDLE cycle later, with s_sel = 1.
  - Repeating the simultaneous request → M0 is granted again (round-robin alternates).
- Backpressure: RREADY_M1 = 0 for 5 cycles with RVALID_S1 = 1 → RVALID_M1 = 1, RREADY_S1 = 0, state stays DATA, and the watchdog does not fire (TIMEOUT_CYC = 256). A beat completes only when RREADY_M1 = 1.
- Isolation: during an M0 → S1 transfer, assert RVALID_S0 and ARVALID_M1 → RVALID_M0 = 0, RREADY_S0 = 0, ARREADY_M1 = 0 throughout.
- Timeout: TIMEOUT_CYC = 8, slave never asserts RVALID → timeout_err pulses for 1 cycle 8 cycles after entering DATA, state = IDLE, and the other master wins the next arbitration.
- Reset mid-burst: ARESETn = 0 during beat 2 → all outputs 0 asynchronously. After release, M0 has priority over a simultaneous M1 request.
